flag_sync: RTL and testbench

Single-clock flag synchronizer and edge-to-pulse converter. It accepts an active-high flag that is asynchronous to the local clock, usually driven from another clock domain. It passes the flag through a multi-stage flop synchronizer and emits a one-cycle pulse in the `clk_dest` domain for each rising edge of the flag. It sits at clock-domain boundaries, for example camera-to-SRAM controller handshakes.

---
 rtl/flag_sync.sv | 95 +++++++++
 tb/tb_flag_sync.sv | 219 +++++++++++++++++++++
 2 files changed

// File: rtl/flag_sync.sv
// Flag synchronizer with rising-edge-to-pulse conversion into the clk_dest domain.
// Define SYNC_FILTER_EN to insert a FILTER_CYCLES deglitch stage ahead of the edge detector.
`timescale 1ns / 1ps

module flag_sync #(
  parameter int unsigned SYNC_STAGES   = 2,
  parameter int unsigned FILTER_CYCLES = 4
) (
  input  logic clk_dest,
  input  logic reset_active_low,
  input  logic flag_in_active_high,
  output logic flag_out_active_high
);

  if (SYNC_STAGES < 2 || SYNC_STAGES > 4) begin : g_bad_sync_stages
    $error("flag_sync: SYNC_STAGES must be in 2..4");
  end

  // Synchronizer chain: bit 0 is the only flop allowed to go metastable and is read
  // solely by bit 1.
  logic [SYNC_STAGES-1:0] sync_q;
  logic                   lvl;

  always_ff @(posedge clk_dest or negedge reset_active_low) begin
    if (!reset_active_low) begin
      sync_q <= '0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], flag_in_active_high};
    end
  end

  assign lvl = sync_q[SYNC_STAGES-1];

  // Level presented to the edge detector.
  logic det_lvl;

`ifdef SYNC_FILTER_EN
  if (FILTER_CYCLES < 2 || FILTER_CYCLES > 15) begin : g_bad_filter_cycles
    $error("flag_sync: FILTER_CYCLES must be in 2..15");
  end

  localparam int unsigned CntW = $clog2(FILTER_CYCLES + 1);

  logic            filt_q, filt_d;
  logic [CntW-1:0] filt_cnt_q, filt_cnt_d;

  // The filtered level flips on the FILTER_CYCLES-th consecutive disagreeing cycle,
  // which adds exactly FILTER_CYCLES edges of latency.
  always_comb begin
    filt_d     = filt_q;
    filt_cnt_d = '0;
    if (lvl != filt_q) begin
      if (filt_cnt_q == CntW'(FILTER_CYCLES - 1)) begin
        filt_d = lvl;
      end else begin
        filt_cnt_d = filt_cnt_q + CntW'(1);
      end
    end
  end

  always_ff @(posedge clk_dest or negedge reset_active_low) begin
    if (!reset_active_low) begin
      filt_q     <= 1'b0;
      filt_cnt_q <= '0;
    end else begin
      filt_q     <= filt_d;
      filt_cnt_q <= filt_cnt_d;
    end
  end

  assign det_lvl = filt_q;
`else
  // FILTER_CYCLES has no effect in this build.
  if (FILTER_CYCLES == 0) begin : g_filter_ignored
  end

  assign det_lvl = lvl;
`endif

  logic prev_q;
  logic pulse_d;

  assign pulse_d = det_lvl & ~prev_q;

  always_ff @(posedge clk_dest or negedge reset_active_low) begin
    if (!reset_active_low) begin
      prev_q               <= 1'b0;
      flag_out_active_high <= 1'b0;
    end else begin
      prev_q               <= det_lvl;
      flag_out_active_high <= pulse_d;
    end
  end

endmodule

// File: tb/tb_flag_sync.sv
// Directed bench for flag_sync: absolute-time scenarios, a per-cycle vector table and
// hand-written reset, glitch and double-pulse sequences.
`timescale 1ns / 1ps

module tb_flag_sync;

  localparam int unsigned SYNC_STAGES   = 2;
  localparam int unsigned FILTER_CYCLES = 4;
  localparam int          PERIOD        = 154;
`ifdef SYNC_FILTER_EN
  localparam int          LAT           = SYNC_STAGES + FILTER_CYCLES;
`else
  localparam int          LAT           = SYNC_STAGES;
`endif

  logic clk_dest;
  logic reset_active_low;
  logic flag_in_active_high;
  logic flag_out_active_high;

  flag_sync #(
    .SYNC_STAGES  (SYNC_STAGES),
    .FILTER_CYCLES(FILTER_CYCLES)
  ) dut (
    .clk_dest            (clk_dest),
    .reset_active_low    (reset_active_low),
    .flag_in_active_high (flag_in_active_high),
    .flag_out_active_high(flag_out_active_high)
  );

  initial begin
    clk_dest = 1'b1;
    forever #(PERIOD / 2) clk_dest = ~clk_dest;
  end

  typedef struct {
    logic rst_n;
    logic flag;
    logic exp;
  } vec_t;

  vec_t vecs[$];
  int   n_checks = 0;
  int   n_fail   = 0;

  task automatic check(input string name, input int got, input int exp);
    n_checks++;
    if (got != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, got, exp, $time);
    end
  endtask

  task automatic add(input logic r, input logic f, input logic e);
    vecs.push_back('{rst_n: r, flag: f, exp: e});
  endtask

  task automatic add_n(input logic r, input logic f, input logic e, input int n);
    for (int i = 0; i < n; i++) add(r, f, e);
  endtask

  // Samples the output 1 ns after each of the next `edges` rising edges.
  task automatic watch(input int edges, output int pulses, output int maxw,
                       output int rise0, output int rise1);
    int w;
    pulses = 0;
    maxw   = 0;
    rise0  = -1;
    rise1  = -1;
    w      = 0;
    for (int e = 0; e < edges; e++) begin
      @(posedge clk_dest);
      #1;
      if (flag_out_active_high === 1'b1) begin
        if (w == 0) begin
          if (pulses == 0) rise0 = int'($time) - 1;
          else if (pulses == 1) rise1 = int'($time) - 1;
          pulses++;
        end
        w++;
        if (w > maxw) maxw = w;
      end else begin
        w = 0;
      end
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not complete, got timeout, expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int pulses, maxw, r0, r1, n;

    // Single 900 ns flag with reset released at 100 ns.
    reset_active_low    = 1'b0;
    flag_in_active_high = 1'b0;
    #1;
    check("reset output", int'(flag_out_active_high), 0);
    #99 reset_active_low = 1'b1;
    fork
      begin
        #2900 flag_in_active_high = 1'b1;
        #900  flag_in_active_high = 1'b0;
      end
      watch(30, pulses, maxw, r0, r1);
    join
    check("single pulse count", pulses, 1);
    check("single pulse width", maxw, 1);
    check("single pulse rise time", r0, 3080 + LAT * PERIOD);

    for (int i = 0; i < 8; i++) @(posedge clk_dest);

`ifdef SYNC_FILTER_EN
    add(1, 0, 0); add_n(1, 1, 0, 6); add(1, 1, 1); add(1, 1, 0);
    add_n(1, 0, 0, 6);
    add_n(1, 1, 0, 2); add_n(1, 0, 0, 6);
    add_n(1, 1, 0, 3); add_n(1, 0, 0, 7);
    add_n(0, 1, 0, 2); add_n(1, 1, 0, 6); add(1, 1, 1); add_n(1, 1, 0, 2);
    add_n(1, 0, 0, 6);
`else
    add(1, 0, 0); add_n(1, 1, 0, 2); add(1, 1, 1); add(1, 1, 0); add_n(1, 0, 0, 3);
    add(1, 1, 0); add(1, 0, 0); add(1, 0, 1); add(1, 0, 0);
    add(1, 1, 0); add(1, 0, 0); add(1, 1, 1); add(1, 0, 0); add(1, 0, 1); add(1, 0, 0);
    add_n(0, 1, 0, 2); add_n(1, 1, 0, 2); add(1, 1, 1); add_n(1, 1, 0, 2);
    add_n(1, 0, 0, 3);
`endif

    @(negedge clk_dest);
    foreach (vecs[i]) begin
      reset_active_low    = vecs[i].rst_n;
      flag_in_active_high = vecs[i].flag;
      @(posedge clk_dest);
      #1;
      check($sformatf("vector %0d", i), int'(flag_out_active_high), int'(vecs[i].exp));
      @(negedge clk_dest);
    end

    // Reset while a pulse is being driven, then release with the flag still high.
    flag_in_active_high = 1'b1;
    n = 0;
    for (int e = 1; e <= LAT + 10; e++) begin
      @(posedge clk_dest);
      #1;
      if (flag_out_active_high === 1'b1) begin
        n = e;
        break;
      end
    end
    check("pulse before mid-pulse reset", int'(n != 0), 1);
    #10 reset_active_low = 1'b0;
    #1;
    check("async reset clears output", int'(flag_out_active_high), 0);
    @(posedge clk_dest);
    #1;
    check("output held in reset", int'(flag_out_active_high), 0);
    @(negedge clk_dest);
    reset_active_low = 1'b1;
    n = 0;
    for (int e = 1; e <= LAT + 6; e++) begin
      @(posedge clk_dest);
      #1;
      if (flag_out_active_high === 1'b1) begin
        n = e;
        break;
      end
    end
    check("release latency edges", n, LAT + 1);
    watch(12, pulses, maxw, r0, r1);
    check("no second pulse after release", pulses, 0);

    // 40 ns glitches: one between edges, one straddling an edge.
    flag_in_active_high = 1'b0;
    for (int i = 0; i < 10; i++) @(posedge clk_dest);
    fork
      begin
        #37 flag_in_active_high = 1'b1;
        #40 flag_in_active_high = 1'b0;
      end
      watch(12, pulses, maxw, r0, r1);
    join
    check("glitch between edges at most one", int'(pulses <= 1), 1);
    check("glitch between edges width", int'(maxw <= 1), 1);
    fork
      begin
        #134 flag_in_active_high = 1'b1;
        #40  flag_in_active_high = 1'b0;
      end
      watch(14, pulses, maxw, r0, r1);
    join
    check("glitch across edge at most one", int'(pulses <= 1), 1);
    check("glitch across edge width", int'(maxw <= 1), 1);

    // 900 ns high, 400 ns low, 900 ns high.
    for (int i = 0; i < 10; i++) @(posedge clk_dest);
    fork
      begin
        #20  flag_in_active_high = 1'b1;
        #900 flag_in_active_high = 1'b0;
        #400 flag_in_active_high = 1'b1;
        #900 flag_in_active_high = 1'b0;
      end
      watch(30, pulses, maxw, r0, r1);
    join
    check("double pulse width", maxw, 1);
`ifdef SYNC_FILTER_EN
    check("short low gap merged by filter", pulses, 1);
`else
    check("double pulse count", pulses, 2);
    check("double pulse spacing", int'((r1 - r0) >= 1300 - PERIOD && (r1 - r0) <= 1300 + PERIOD), 1);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
